mc_control_fsm: RTL and testbench

//  Main control state machine of the multicycle datapath. Decodes the latched opcode and sequences

---
 rtl/mc_control_fsm_pkg.sv | 61 ++++++
 rtl/mc_ctrl_decode.sv | 86 ++++++++
 rtl/mc_control_fsm.sv | 104 ++++++++++
 tb/tb_mc_control_fsm.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
// rtl/mc_control_fsm_pkg.sv - shared state, opcode and mux-select encodings for the multicycle control path
package mc_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REXE   = 4'd7,
        S_RWB    = 4'd8,
        S_BEQ    = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JMP    = 4'd12
    } state_e;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational state + mem_ready to control-word decode
module mc_ctrl_decode
    import mc_control_fsm_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o,
    output logic   instr_done_o
);

    always_comb begin
        ctrl_o       = '0;
        instr_done_o = 1'b0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // IR and PC must not load on a fetch the memory has not completed
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                instr_done_o      = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
                instr_done_o     = mem_ready_i;
            end
            S_REXE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
                instr_done_o     = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_B;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                instr_done_o         = 1'b1;
            end
            S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl_o.reg_write = 1'b1;
                instr_done_o     = 1'b1;
            end
            S_JMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
                instr_done_o     = 1'b1;
            end
            default: begin
                ctrl_o       = '0;
                instr_done_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle datapath main control FSM with retired-instruction counter
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic             is_sw_q;
    logic [CNT_W-1:0] count_q;
    ctrl_t            ctrl;

    mc_ctrl_decode u_decode (
        .state_i      (state_q),
        .mem_ready_i  (mem_ready),
        .ctrl_o       (ctrl),
        .instr_done_o (instr_done)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign instr_count = count_q;

    assign illegal_op = (state_q == S_DECODE) && !op_is_legal(opcode);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_REXE;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            // lw/sw choice uses the opcode captured in DECODE, not the live IR bits
            S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_REXE:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JMP:    state_d = S_FETCH;
            default:  state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RST;
            is_sw_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                is_sw_q <= (opcode == OP_SW);
            end
            if (instr_done) begin
                count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - randomized trace-level check of mc_control_fsm against an instruction-phase model
module tb_mc_control_fsm;

    localparam int CW = 8;

    typedef enum int {P_RST, P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                      P_REXE, P_RWB, P_BEQ, P_ADDIEX, P_ADDIWB, P_JMP} phase_e;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    opcode;
    logic          mem_ready;
    logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic          MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op, instr_done;
    logic [1:0]    ALUSrcB, ALUOp, PCSource;
    logic [CW-1:0] instr_count;
    logic [CW-1:0] exp_count;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    mc_control_fsm #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .instr_done(instr_done),
        .instr_count(instr_count)
    );

    wire [19:0] got_cw = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                          RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, instr_done};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // Expected control word written directly from the per-phase output table
    function automatic logic [19:0] expect_cw(input phase_e ph, input logic mr, input logic [5:0] op);
        logic pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill, done;
        logic [1:0] sb, aop, pcs;
        {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill, done} = '0;
        {sb, aop, pcs} = '0;
        case (ph)
            P_FETCH:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            P_DECODE: begin sb = 2'b11; ill = !is_legal(op); end
            P_MEMADR: begin asa = 1; sb = 2'b10; end
            P_MEMRD:  begin mrd = 1; iord = 1; end
            P_MEMWB:  begin rw = 1; m2r = 1; done = 1; end
            P_MEMWR:  begin mwr = 1; iord = 1; done = mr; end
            P_REXE:   begin asa = 1; aop = 2'b10; end
            P_RWB:    begin rw = 1; rdst = 1; done = 1; end
            P_BEQ:    begin asa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; done = 1; end
            P_ADDIEX: begin asa = 1; sb = 2'b10; end
            P_ADDIWB: begin rw = 1; done = 1; end
            P_JMP:    begin pcw = 1; pcs = 2'b10; done = 1; end
            default:  ;
        endcase
        return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, sb, aop, pcs, ill, done};
    endfunction

    // One cycle: entered and left at a negedge; opcode is scrambled outside DECODE
    task automatic step(input phase_e ph, input logic mr, input logic [5:0] op);
        mem_ready = mr;
        opcode = (ph == P_DECODE) ? op : 6'($urandom);
        #1;
        check_eq($sformatf("cw_%s", ph.name()), {12'd0, got_cw}, {12'd0, expect_cw(ph, mr, op)});
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) step(P_FETCH, 1'b0, op);
        step(P_FETCH, 1'b1, op);
        step(P_DECODE, rnd_bit(), op);
        case (op)
            6'b100011: begin
                step(P_MEMADR, rnd_bit(), op);
                for (int i = 0; i < mw; i++) step(P_MEMRD, 1'b0, op);
                step(P_MEMRD, 1'b1, op);
                step(P_MEMWB, rnd_bit(), op);
            end
            6'b101011: begin
                step(P_MEMADR, rnd_bit(), op);
                for (int i = 0; i < mw; i++) step(P_MEMWR, 1'b0, op);
                step(P_MEMWR, 1'b1, op);
            end
            6'b000000: begin step(P_REXE, rnd_bit(), op); step(P_RWB, rnd_bit(), op); end
            6'b000100: step(P_BEQ, rnd_bit(), op);
            6'b001000: begin step(P_ADDIEX, rnd_bit(), op); step(P_ADDIWB, rnd_bit(), op); end
            6'b000010: step(P_JMP, rnd_bit(), op);
            default: ;
        endcase
        if (is_legal(op)) exp_count = exp_count + 1'b1;
        check_eq("count", {24'd0, instr_count}, {24'd0, exp_count});
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        int guard;
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
        ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;
        rst_n = 1'b0; opcode = '0; mem_ready = 1'b0; exp_count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_cw", {12'd0, got_cw}, 32'd0);
        check_eq("reset_count", {24'd0, instr_count}, 32'd0);
        rst_n = 1'b1;
        step(P_RST, 1'b1, 6'd0);

        run_instr(6'b100011, 0, 0);
        run_instr(6'b101011, 0, 3);
        run_instr(6'b000000, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(6'b100011, 2, 1);

        // reset while a load waits in MEMRD
        step(P_FETCH, 1'b1, 6'b100011);
        step(P_DECODE, 1'b1, 6'b100011);
        step(P_MEMADR, 1'b1, 6'b100011);
        rst_n = 1'b0;
        step(P_MEMRD, 1'b0, 6'b100011);
        rst_n = 1'b1;
        exp_count = '0;
        check_eq("midreset_count", {24'd0, instr_count}, 32'd0);
        step(P_RST, 1'b1, 6'd0);
        step(P_FETCH, 1'b0, 6'd0);

        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        guard = 0;
        while (exp_count != {CW{1'b1}} && guard < 300) begin
            run_instr(6'b000010, 0, 0);
            guard++;
        end
        check_eq("reach_all_ones", {24'd0, instr_count}, {24'd0, {CW{1'b1}}});
        run_instr(6'b000010, 0, 0);
        check_eq("wrap_zero", {24'd0, instr_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
